uart_msg_sequencer: RTL

Byte-level message sequencer sitting directly upstream of the UART serializer in the dispatcher path. On a start request it walks the ASCII encoder's byte index from 0 to `msg_len-1`, latches each encoded byte, and issues one-cycle `transmit` strobes. It paces each strobe on the serializer's frame-done pulse plus a programmable inter-byte gap, and aborts on a per-byte watchdog timeout. Optionally it appends an XOR checksum byte.

---
 rtl/uart_seq_pkg.sv | 24 ++
 rtl/seq_timer.sv | 42 ++++
 rtl/uart_msg_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and defaults for the UART message sequencer and its timer.
package uart_seq_pkg;

    localparam int LOAD_CYCLES        = 2;
    localparam int DEFAULT_GAP_CYCLES = 16;
    localparam int DEFAULT_TIMEOUT    = 131072;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        GAP,
        CHK,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        TMR_LOAD,
        TMR_GAP,
        TMR_TIMEOUT
    } timer_sel_t;

endpackage

// File: rtl/seq_timer.sv
// Shared up-counter for the sequencer; hit flags the last cycle of the selected interval.
module seq_timer
    import uart_seq_pkg::*;
#(
    parameter int CNT_W      = 18,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  timer_sel_t sel,
    output logic       hit
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Limits are terminal counts: an N-cycle interval hits when the count reads N-1.
    always_comb begin
        limit = CNT_W'(TIMEOUT - 1);
        case (sel)
            TMR_LOAD: limit = CNT_W'(LOAD_CYCLES - 1);
            TMR_GAP:  limit = CNT_W'(GAP_CYCLES - 1);
            default:  limit = CNT_W'(TIMEOUT - 1);
        endcase
    end

    assign hit = (count_reg == limit);

endmodule

// File: rtl/uart_msg_sequencer.sv
// Walks encoder byte indices, latches each byte and paces transmit strobes on tx_done.
// Define UART_SEQ_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module uart_msg_sequencer
    import uart_seq_pkg::*;
#(
    parameter int LEN_W      = 7,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CNT_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic [DATA_W-1:0] cod_data,
    input  logic              tx_done,
    output logic [LEN_W-1:0]  cnt_idx,
    output logic [DATA_W-1:0] tx_data,
    output logic              transmit,
    output logic              busy,
    output logic              msg_done,
    output logic              err
);

    seq_state_t        state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  cnt_idx_reg, cnt_idx_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              transmit_reg, busy_reg, msg_done_reg, err_reg;
    logic              err_next;
    timer_sel_t        tmr_sel;
    logic              tmr_clr, tmr_en, tmr_hit;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] chk_reg, chk_next;
    logic              chk_sent_reg, chk_sent_next;
`endif

    // Restart the interval on every state change so each timed state starts from zero.
    assign tmr_clr = (state_next != state_reg);
    assign tmr_en  = (state_reg == LOAD) || (state_reg == WAIT) || (state_reg == GAP);

    seq_timer #(
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .sel (tmr_sel),
        .hit (tmr_hit)
    );

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        cnt_idx_next = cnt_idx_reg;
        tx_data_next = tx_data_reg;
        err_next     = 1'b0;
        tmr_sel      = TMR_TIMEOUT;
`ifdef UART_SEQ_CHECKSUM_EN
        chk_next      = chk_reg;
        chk_sent_next = chk_sent_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next     = msg_len;
                    cnt_idx_next = '0;
`ifdef UART_SEQ_CHECKSUM_EN
                    chk_next      = '0;
                    chk_sent_next = 1'b0;
`endif
                    state_next = (msg_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                tmr_sel = TMR_LOAD;
                if (tmr_hit) begin
                    tx_data_next = cod_data;
`ifdef UART_SEQ_CHECKSUM_EN
                    chk_next = chk_reg ^ cod_data;
`endif
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                tmr_sel = TMR_TIMEOUT;
                // A frame completing on the timeout cycle still counts as delivered.
                if (tx_done) begin
`ifdef UART_SEQ_CHECKSUM_EN
                    state_next = chk_sent_reg ? DONE : GAP;
`else
                    state_next = GAP;
`endif
                end else if (tmr_hit) begin
                    err_next     = 1'b1;
                    cnt_idx_next = '0;
                    state_next   = IDLE;
                end
            end
            GAP: begin
                tmr_sel = TMR_GAP;
                if (tmr_hit) begin
                    if (cnt_idx_reg < len_reg - 1'b1) begin
                        cnt_idx_next = cnt_idx_reg + 1'b1;
                        state_next   = LOAD;
                    end else begin
`ifdef UART_SEQ_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef UART_SEQ_CHECKSUM_EN
            CHK: begin
                tx_data_next  = chk_reg;
                chk_sent_next = 1'b1;
                state_next    = SEND;
            end
`endif
            DONE: begin
                cnt_idx_next = '0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are flopped from the next state so nothing combinational reaches a port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            cnt_idx_reg  <= '0;
            tx_data_reg  <= '0;
            transmit_reg <= 1'b0;
            busy_reg     <= 1'b0;
            msg_done_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            cnt_idx_reg  <= cnt_idx_next;
            tx_data_reg  <= tx_data_next;
            transmit_reg <= (state_next == SEND);
            busy_reg     <= (state_next != IDLE);
            msg_done_reg <= (state_next == DONE);
            err_reg      <= err_next;
        end
    end

`ifdef UART_SEQ_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_reg      <= '0;
            chk_sent_reg <= 1'b0;
        end else begin
            chk_reg      <= chk_next;
            chk_sent_reg <= chk_sent_next;
        end
    end
`endif

    assign cnt_idx  = cnt_idx_reg;
    assign tx_data  = tx_data_reg;
    assign transmit = transmit_reg;
    assign busy     = busy_reg;
    assign msg_done = msg_done_reg;
    assign err      = err_reg;

endmodule
